lsu: RTL

Load/store unit for the single-cycle NPC: the initiator side of the 256×32 data RAM port. It accepts one byte, halfword or word load/store at a time from the core over a valid/ready handshake. It drives the RAM's combinational read port and registered write port, performs read-modify-write for sub-word stores, and returns lane-extracted, sign- or zero-extended load data as a one-cycle response pulse.

---
 rtl/lsu.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/lsu.sv
// Load/store unit: initiator for the 256x32 data RAM, read-modify-write for sub-word stores.
// Build option LSU_MISALIGN_TRAP_EN: misaligned half/word accesses respond with resp_err instead of aligning.
module lsu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [7:0]  ram_raddr,
  input  logic [31:0] ram_rdata,
  output logic [7:0]  ram_waddr,
  output logic [31:0] ram_wdata,
  output logic        ram_wen
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned IDXW = 8;
  localparam int unsigned HALF = 16;
  localparam int unsigned BYTE = 8;

  typedef enum logic [2:0] {IDLE, LOAD, MERGE, WRITE, RESP} state_e;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic              uns_q, uns_d;
  logic [HALF-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   wbuf_q, wbuf_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;

  logic              misalign_c;
  logic [BYTE-1:0]   lane_b;
  logic [HALF-1:0]   lane_h;
  logic [XLEN-1:0]   load_c;
  logic [XLEN-1:0]   merge_c;
  logic              unused_addr;

  assign unused_addr = ^req_addr[31:10];

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign_c = ((req_size == 2'd1) && req_addr[0]) ||
                      (req_size[1] && (req_addr[1:0] != 2'b00));
`else
  assign misalign_c = 1'b0;
`endif

  // Lane extraction for loads and lane insertion for sub-word stores.
  always_comb begin
    lane_b = ram_rdata[{off_q, 3'b000} +: BYTE];
    lane_h = ram_rdata[{off_q[1], 4'b0000} +: HALF];
    case (size_q)
      2'd0:    load_c = uns_q ? {{(XLEN-BYTE){1'b0}}, lane_b}
                              : {{(XLEN-BYTE){lane_b[BYTE-1]}}, lane_b};
      2'd1:    load_c = uns_q ? {{(XLEN-HALF){1'b0}}, lane_h}
                              : {{(XLEN-HALF){lane_h[HALF-1]}}, lane_h};
      default: load_c = ram_rdata;
    endcase
    merge_c = ram_rdata;
    if (size_q == 2'd0) merge_c[{off_q, 3'b000} +: BYTE] = wdata_q[BYTE-1:0];
    else                merge_c[{off_q[1], 4'b0000} +: HALF] = wdata_q;
  end

  // Next-state and datapath capture.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    off_d   = off_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    wbuf_d  = wbuf_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          idx_d   = req_addr[9:2];
          off_d   = req_addr[1:0];
          size_d  = req_size;
          uns_d   = req_unsigned;
          wdata_d = req_wdata[HALF-1:0];
          rdata_d = '0;
          err_d   = misalign_c;
          if (misalign_c) begin
            state_d = RESP;
          end else if (!req_we) begin
            state_d = LOAD;
          end else if (req_size[1]) begin
            wbuf_d  = req_wdata;
            state_d = WRITE;
          end else begin
            state_d = MERGE;
          end
        end
      end
      LOAD: begin
        rdata_d = load_c;
        state_d = RESP;
      end
      MERGE: begin
        wbuf_d  = merge_c;
        state_d = WRITE;
      end
      WRITE:   state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q   <= '0;
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      wbuf_q  <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      wbuf_q  <= wbuf_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Handshake and write strobe decode straight from the state register.
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP);
  assign ram_wen    = (state_q == WRITE);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign ram_raddr  = idx_q;
  assign ram_waddr  = idx_q;
  assign ram_wdata  = wbuf_q;

endmodule
